cpu_io_tx: RTL and testbench

- Output peripheral directly downstream of the CPU core.
- Captures the execute-stage result word whenever the core flags an IO output, and buffers captured words in a small FIFO.
- Serializes each word byte-by-byte on an 8N1 UART transmit line so results can be observed off-chip.

---
 rtl/cpu_io_tx.sv | 246 ++++++++++++++++++++++++
 tb/tb_cpu_io_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_tx.sv
// cpu_io_tx: captures execute-stage result words into a small FIFO and
// serializes each word little-endian, byte by byte, on an 8N1 UART line.
// Optional build macro IO_TX_FRAME_EN wraps every word as
// sync byte 8'hA5, WIDTH/8 data bytes, then an XOR checksum of the data bytes.
module cpu_io_tx #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     outFlagIOE,
  input  logic [WIDTH-1:0]         out,
  output logic                     tx,
  output logic                     busy,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned NumBytes = WIDTH / 8;
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned OccW     = PtrW + 1;
  localparam int unsigned CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  localparam logic [CntW-1:0]  BaudLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [ByteW-1:0] ByteLast  = ByteW'(NumBytes - 1);
  localparam logic [OccW-1:0]  OccFull   = OccW'(DEPTH);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;

`ifdef IO_TX_FRAME_EN
  localparam logic [1:0] PhSync = 2'd0;
  localparam logic [1:0] PhData = 2'd1;
  localparam logic [1:0] PhCsum = 2'd2;

  // XOR of all data bytes of a word; the sync byte is not part of it.
  function automatic logic [7:0] xor_bytes(input logic [WIDTH-1:0] w);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < int'(NumBytes); i++) begin
      acc = acc ^ w[8*i +: 8];
    end
    return acc;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             push;
  logic             pop;

  // Serializer state
  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [ByteW-1:0] byte_idx_q, byte_idx_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             tx_q, tx_d;
  logic [7:0]       tx_byte_d;
  logic             baud_end;

`ifdef IO_TX_FRAME_EN
  logic [1:0]       phase_q, phase_d;
  logic [7:0]       csum_q, csum_d;
`endif

  // FIFO next state; full is judged on the pre-edge occupancy so a same-edge pop
  // never rescues a push into a full FIFO.
  always_comb begin
    push       = outFlagIOE & ~full_q;
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q + OccW'(push) - OccW'(pop);
    full_d     = (count_d == OccFull);
    overflow_d = overflow_q | (outFlagIOE & full_q);
  end

  // Serializer FSM: next state, baud/bit/byte counters and shift register.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    sr_d       = sr_q;
    pop        = 1'b0;
    baud_end   = (baud_q == BaudLast);
`ifdef IO_TX_FRAME_EN
    phase_d    = phase_q;
    csum_d     = csum_q;
`endif
    case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StLoad;
      end
      StLoad: begin
        // Only reachable with a non-empty FIFO, so the pop is always valid.
        pop        = 1'b1;
        sr_d       = mem_q[rd_ptr_q];
        byte_idx_d = '0;
        bit_idx_d  = '0;
        baud_d     = '0;
        state_d    = StStart;
`ifdef IO_TX_FRAME_EN
        phase_d    = PhSync;
        csum_d     = xor_bytes(mem_q[rd_ptr_q]);
`endif
      end
      StStart: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
`ifdef IO_TX_FRAME_EN
          case (phase_q)
            PhSync: begin
              phase_d = PhData;
              state_d = StStart;
            end
            PhData: begin
              state_d = StStart;
              if (byte_idx_q != ByteLast) begin
                byte_idx_d = byte_idx_q + ByteW'(1);
                sr_d       = sr_q >> 8;
              end else begin
                phase_d = PhCsum;
              end
            end
            default: state_d = (count_q != '0) ? StLoad : StIdle;
          endcase
`else
          if (byte_idx_q != ByteLast) begin
            byte_idx_d = byte_idx_q + ByteW'(1);
            sr_d       = sr_q >> 8;
            state_d    = StStart;
          end else begin
            state_d = (count_q != '0) ? StLoad : StIdle;
          end
`endif
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the next cycle, derived from next-state values so tx is a clean flop.
  always_comb begin
`ifdef IO_TX_FRAME_EN
    case (phase_d)
      PhSync:  tx_byte_d = 8'hA5;
      PhCsum:  tx_byte_d = csum_d;
      default: tx_byte_d = sr_d[7:0];
    endcase
`else
    tx_byte_d = sr_d[7:0];
`endif
    tx_d = 1'b1;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = tx_byte_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      sr_q       <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef IO_TX_FRAME_EN
      phase_q    <= PhSync;
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      sr_q       <= sr_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
`ifdef IO_TX_FRAME_EN
      phase_q    <= phase_d;
      csum_q     <= csum_d;
`endif
    end
  end

  // FIFO storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= out;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle) || (count_q != '0);
  assign full     = full_q;
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule

// File: tb/tb_cpu_io_tx.sv
// Scoreboard bench for cpu_io_tx: stimulus queues the expected serial bytes,
// a UART monitor decodes tx and compares each frame against the queue.
module tb_cpu_io_tx;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned C  = 4;
`ifdef IO_TX_FRAME_EN
  localparam int unsigned BytesPerWord = W / 8 + 2;
`else
  localparam int unsigned BytesPerWord = W / 8;
`endif
  localparam int unsigned FrameCycles = 10 * C * BytesPerWord;

  typedef struct {
    logic [7:0] data;
    int         gap;  // expected idle cycles before this start bit, -1 = don't care
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         outFlagIOE;
  logic [W-1:0] out;
  logic         tx;
  logic         busy;
  logic         full;
  logic         overflow;
  logic [2:0]   count;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  cpu_io_tx #(
    .WIDTH        (W),
    .DEPTH        (D),
    .CLKS_PER_BIT (C)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .outFlagIOE (outFlagIOE),
    .out        (out),
    .tx         (tx),
    .busy       (busy),
    .full       (full),
    .overflow   (overflow),
    .count      (count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [W-1:0] w);
    outFlagIOE = 1'b1;
    out        = w;
    tick();
    outFlagIOE = 1'b0;
  endtask

  // Queue the serial bytes of one word; only the first nbytes are kept.
  task automatic expect_word(input logic [W-1:0] w, input int gap, input int nbytes);
    exp_t       seq[$];
    logic [7:0] csum;
    csum = 8'h00;
`ifdef IO_TX_FRAME_EN
    seq.push_back('{8'hA5, gap});
    for (int i = 0; i < int'(W / 8); i++) begin
      seq.push_back('{w[8*i +: 8], 0});
      csum = csum ^ w[8*i +: 8];
    end
    seq.push_back('{csum, 0});
`else
    for (int i = 0; i < int'(W / 8); i++) begin
      seq.push_back('{w[8*i +: 8], (i == 0) ? gap : 0});
    end
`endif
    for (int i = 0; i < nbytes && i < seq.size(); i++) exp_q.push_back(seq[i]);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  // UART monitor: every bit must hold its level for all C cycles.
  initial begin : monitor
    int         s;
    int         prev_start;
    int         pos;
    logic [7:0] b;
    logic       ok;
    logic       aborted;
    exp_t       e;
    prev_start = -1000000;
    forever begin
      @(negedge clock);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      s       = cyc;
      ok      = 1'b1;
      aborted = 1'b0;
      b       = 8'h00;
      for (int k = 0; k < int'(10 * C); k++) begin
        if (k > 0) @(negedge clock);
        if (reset !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        pos = k / int'(C);
        if (pos == 0) begin
          if (tx !== 1'b0) ok = 1'b0;
        end else if (pos == 9) begin
          if (tx !== 1'b1) ok = 1'b0;
        end else if (k % int'(C) == 0) begin
          b[pos-1] = tx;
        end else if (tx !== b[pos-1]) begin
          ok = 1'b0;
        end
      end
      if (aborted) continue;
      chk("sb_byte_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_byte_value", {ok, b}, {1'b1, e.data});
        if (e.gap >= 0) chk("sb_start_gap", s - (prev_start + int'(10 * C)), e.gap);
      end
      prev_start = s;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int bad;
    reset      = 1'b1;
    outFlagIOE = 1'b0;
    out        = '0;
    tick();
    reset = 1'b0;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_count", count, 3'd0);

    // Idle line
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_bad_cycles", bad, 0);
    chk("idle_count", count, 3'd0);
    chk("idle_overflow", overflow, 1'b0);

    // Single word: latency and frame length
    expect_word(32'h12345678, -1, 99);
    pulse(32'h12345678);
    chk("one_count_after_push", count, 3'd1);
    chk("one_busy_after_push", busy, 1'b1);
    tick();
    chk("one_tx_load", tx, 1'b1);
    tick();
    chk("one_tx_start", tx, 1'b0);
    chk("one_count_popped", count, 3'd0);
    repeat (FrameCycles - 1) tick();
    chk("one_busy_last_stop", busy, 1'b1);
    tick();
    chk("one_busy_done", busy, 1'b0);
    chk("one_tx_done", tx, 1'b1);
    chk("one_sb_empty", exp_q.size(), 0);

    // Six pulses while the serializer is mid-byte: four fit, two drop
    expect_word(32'hCAFEF00D, -1, 99);
    pulse(32'hCAFEF00D);
    repeat (10) tick();
    for (int i = 1; i <= 6; i++) begin
      pulse(W'(i));
      if (i <= 4) expect_word(W'(i), 1, 99);
      chk("burst_count", count, (i < 4) ? i : 4);
      chk("burst_full", full, i >= 4);
      chk("burst_overflow", overflow, i > 4);
    end
    wait_idle(3000, "burst_idle_timeout");
    chk("burst_sb_empty", exp_q.size(), 0);
    chk("burst_overflow_sticky", overflow, 1'b1);

    // Push on the same edge that LOAD pops
    expect_word(32'h8, -1, 99);
    expect_word(32'h9, 1, 99);
    pulse(32'h8);
    tick();
    pulse(32'h9);
    chk("pp_count", count, 3'd1);
    chk("pp_full", full, 1'b0);
    wait_idle(2000, "pp_idle_timeout");
    chk("pp_sb_empty", exp_q.size(), 0);

    // Reset during the data bits of the third serial byte
    expect_word(32'hDEADBEEF, -1, 2);
    pulse(32'hDEADBEEF);
    repeat (2 + 20 * C + C + 8) tick();
    chk("mid_busy_before_reset", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_tx", tx, 1'b1);
    chk("mid_count", count, 3'd0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_overflow", overflow, 1'b0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    chk("mid_quiet_cycles", bad, 0);
    chk("mid_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
